// File: rtl/fpu_request_sequencer.sv
// Command front-end for the FPU divide/sqrt core: operand strobe/ack issue, result capture, response port.
// Optional watchdog with ERROR state enabled by defining FPU_SEQ_TIMEOUT_EN.
module fpu_request_sequencer #(
    parameter int unsigned TAG_W          = 4,
    parameter int unsigned LAT_W          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [63:0]      cmd_a,
    input  logic [63:0]      cmd_b,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [1:0]       fpu_process,
    output logic [31:0]      fpu_as,
    output logic [31:0]      fpu_bs,
    output logic [63:0]      fpu_ad,
    output logic [63:0]      fpu_bd,
    output logic             fpu_a_stb,
    input  logic             fpu_a_ack,
    output logic             fpu_b_stb,
    input  logic             fpu_b_ack,
    input  logic [31:0]      fpu_zs,
    input  logic [63:0]      fpu_zd,
    input  logic             fpu_z_stb,
    output logic             fpu_z_ack,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [63:0]      rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [1:0]       rsp_op,
    output logic [LAT_W-1:0] rsp_lat,
    output logic             rsp_err
);

`ifdef FPU_SEQ_TIMEOUT_EN
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_Z, S_DRAIN, S_ERROR} state_t;
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
`else
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_Z, S_DRAIN} state_t;
`endif

    state_t             state_q, state_d;
    logic               ready_q;
    logic [1:0]         op_q, op_d;
    logic [63:0]        a_q, a_d, b_q, b_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               a_pend_q, a_pend_d, b_pend_q, b_pend_d;
    logic [LAT_W-1:0]   lat_q, lat_d, lat_inc;
    logic               rsp_valid_q, rsp_valid_d;
    logic [63:0]        rsp_data_q, rsp_data_d;
    logic [TAG_W-1:0]   rsp_tag_q, rsp_tag_d;
    logic [1:0]         rsp_op_q, rsp_op_d;
    logic [LAT_W-1:0]   rsp_lat_q, rsp_lat_d;
    logic               z_fire;
`ifdef FPU_SEQ_TIMEOUT_EN
    logic [WD_W-1:0]    wd_q, wd_d, wd_inc;
    logic               err_pend_q, err_pend_d;
    logic               rsp_err_q, rsp_err_d;
    logic               tmo;
`endif

    // Registered ready keeps cmd_ready low during reset and for the first cycle after release.
    assign cmd_ready   = ready_q;
    assign fpu_process = op_q;
    assign fpu_as      = a_q[31:0];
    assign fpu_bs      = b_q[31:0];
    assign fpu_ad      = a_q;
    assign fpu_bd      = b_q;
    assign fpu_a_stb   = (state_q == S_ISSUE) & a_pend_q;
    assign fpu_b_stb   = (state_q == S_ISSUE) & b_pend_q;
    assign fpu_z_ack   = (state_q == S_WAIT_Z) & fpu_z_stb & ~rsp_valid_q;
    assign z_fire      = fpu_z_ack;
    assign lat_inc     = (lat_q == '1) ? lat_q : lat_q + 1'b1;

    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_tag     = rsp_tag_q;
    assign rsp_op      = rsp_op_q;
    assign rsp_lat     = rsp_lat_q;
`ifdef FPU_SEQ_TIMEOUT_EN
    assign rsp_err     = rsp_err_q;
    assign wd_inc      = wd_q + 1'b1;
    assign tmo         = ((state_q == S_ISSUE) || (state_q == S_WAIT_Z)) && !z_fire
                         && (wd_inc == WD_W'(TIMEOUT_CYCLES));
`else
    assign rsp_err     = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        tag_d       = tag_q;
        a_pend_d    = a_pend_q;
        b_pend_d    = b_pend_q;
        lat_d       = lat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_tag_d   = rsp_tag_q;
        rsp_op_d    = rsp_op_q;
        rsp_lat_d   = rsp_lat_q;
`ifdef FPU_SEQ_TIMEOUT_EN
        wd_d        = wd_q;
        err_pend_d  = err_pend_q;
        rsp_err_d   = rsp_err_q;
`endif
        if (rsp_valid_q && rsp_ready)
            rsp_valid_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    op_d     = cmd_op;
                    a_d      = cmd_a;
                    b_d      = cmd_b;
                    tag_d    = cmd_tag;
                    a_pend_d = 1'b1;
                    b_pend_d = ~cmd_op[0];
                    lat_d    = '0;
                    state_d  = S_ISSUE;
`ifdef FPU_SEQ_TIMEOUT_EN
                    wd_d     = '0;
`endif
                end
            end
            S_ISSUE: begin
                lat_d    = lat_inc;
                a_pend_d = a_pend_q & ~(fpu_a_stb & fpu_a_ack);
                b_pend_d = b_pend_q & ~(fpu_b_stb & fpu_b_ack);
                if (!a_pend_d && !b_pend_d)
                    state_d = S_WAIT_Z;
            end
            S_WAIT_Z: begin
                lat_d = lat_inc;
                if (z_fire) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = op_q[1] ? fpu_zd : {32'b0, fpu_zs};
                    rsp_tag_d   = tag_q;
                    rsp_op_d    = op_q;
                    rsp_lat_d   = lat_inc;
                    state_d     = S_DRAIN;
`ifdef FPU_SEQ_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
`endif
                end
            end
            S_DRAIN: begin
                if (!fpu_z_stb)
                    state_d = S_IDLE;
            end
`ifdef FPU_SEQ_TIMEOUT_EN
            S_ERROR: ;
`endif
            default: state_d = S_IDLE;
        endcase

`ifdef FPU_SEQ_TIMEOUT_EN
        if ((state_q == S_ISSUE) || (state_q == S_WAIT_Z))
            wd_d = wd_inc;
        if (tmo) begin
            a_pend_d   = 1'b0;
            b_pend_d   = 1'b0;
            err_pend_d = 1'b1;
            state_d    = S_ERROR;
        end
        // Error response waits for the response register to be free, like a normal capture.
        if (err_pend_d && !rsp_valid_q) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = 64'h7FF8_0000_0000_0000;
            rsp_tag_d   = tag_q;
            rsp_op_d    = op_q;
            rsp_lat_d   = lat_d;
            rsp_err_d   = 1'b1;
            err_pend_d  = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            tag_q       <= '0;
            a_pend_q    <= 1'b0;
            b_pend_q    <= 1'b0;
            lat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_tag_q   <= '0;
            rsp_op_q    <= '0;
            rsp_lat_q   <= '0;
`ifdef FPU_SEQ_TIMEOUT_EN
            wd_q        <= '0;
            err_pend_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ready_q     <= (state_d == S_IDLE);
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            tag_q       <= tag_d;
            a_pend_q    <= a_pend_d;
            b_pend_q    <= b_pend_d;
            lat_q       <= lat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_op_q    <= rsp_op_d;
            rsp_lat_q   <= rsp_lat_d;
`ifdef FPU_SEQ_TIMEOUT_EN
            wd_q        <= wd_d;
            err_pend_q  <= err_pend_d;
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_fpu_request_sequencer.sv
// Directed bench for fpu_request_sequencer; the FPU side is driven by hand from the stimulus.
module tb_fpu_request_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = '0;
    logic [63:0] cmd_a = '0, cmd_b = '0;
    logic [3:0]  cmd_tag = '0;
    logic [1:0]  fpu_process;
    logic [31:0] fpu_as, fpu_bs;
    logic [63:0] fpu_ad, fpu_bd;
    logic        fpu_a_stb, fpu_b_stb, fpu_z_ack;
    logic        fpu_a_ack = 1'b0, fpu_b_ack = 1'b0, fpu_z_stb = 1'b0;
    logic [31:0] fpu_zs = '0;
    logic [63:0] fpu_zd = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [63:0] rsp_data;
    logic [3:0]  rsp_tag;
    logic [1:0]  rsp_op;
    logic [15:0] rsp_lat;
    logic        rsp_err;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    fpu_request_sequencer #(
        .TAG_W(4),
        .LAT_W(16),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
        .fpu_process(fpu_process), .fpu_as(fpu_as), .fpu_bs(fpu_bs),
        .fpu_ad(fpu_ad), .fpu_bd(fpu_bd),
        .fpu_a_stb(fpu_a_stb), .fpu_a_ack(fpu_a_ack),
        .fpu_b_stb(fpu_b_stb), .fpu_b_ack(fpu_b_ack),
        .fpu_zs(fpu_zs), .fpu_zd(fpu_zd), .fpu_z_stb(fpu_z_stb), .fpu_z_ack(fpu_z_ack),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_tag(rsp_tag), .rsp_op(rsp_op), .rsp_lat(rsp_lat), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [3:0] tag);
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag; cmd_valid = 1'b1;
        #1;
        check("send_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        #1;
    endtask

    initial begin
        // Reset values
        #2;
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_strobes", {fpu_a_stb, fpu_b_stb, fpu_z_ack}, 0);
        check("rst_rsp", {rsp_valid, rsp_err}, 0);
        check("rst_fpu_ad", fpu_ad, 0);
        #20 rst = 1'b0;
        #1 check("rel_cmd_ready_low", cmd_ready, 0);
        tick();
        check("rel_cmd_ready_high", cmd_ready, 1);

        // Single div: A acked in the first ISSUE cycle, B two cycles later
        send(2'd0, 64'h0000_0000_4040_0000, 64'h0000_0000_3F80_0000, 4'd5);
        check("sd_a_stb", fpu_a_stb, 1);
        check("sd_b_stb", fpu_b_stb, 1);
        check("sd_process", fpu_process, 0);
        check("sd_as", fpu_as, 32'h4040_0000);
        check("sd_bs", fpu_bs, 32'h3F80_0000);
        check("sd_busy", cmd_ready, 0);
        fpu_a_ack = 1'b1;
        tick();
        fpu_a_ack = 1'b0;
        #1;
        check("sd_a_dropped", fpu_a_stb, 0);
        check("sd_b_held", fpu_b_stb, 1);
        tick();
        fpu_b_ack = 1'b1;
        tick();
        fpu_b_ack = 1'b0;
        #1;
        check("sd_both_dropped", {fpu_a_stb, fpu_b_stb}, 0);
        fpu_zs = 32'h4040_0000; fpu_zd = 64'hFFFF_FFFF_FFFF_FFFF; fpu_z_stb = 1'b1;
        #1;
        check("sd_z_ack", fpu_z_ack, 1);
        tick();
        check("sd_rsp_valid", rsp_valid, 1);
        check("sd_rsp_data", rsp_data, 64'h0000_0000_4040_0000);
        check("sd_rsp_tag", rsp_tag, 5);
        check("sd_rsp_op", rsp_op, 0);
        check("sd_rsp_lat", rsp_lat, 4);
        check("sd_rsp_err", rsp_err, 0);
        check("sd_drain_no_ack", fpu_z_ack, 0);
        fpu_z_stb = 1'b0; rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("sd_rsp_taken", rsp_valid, 0);
        check("sd_idle", cmd_ready, 1);

        // Double sqrt: no B phase, double result selected
        send(2'd3, 64'h4010_0000_0000_0000, 64'h0000_0000_0000_1234, 4'd9);
        check("dq_a_stb", fpu_a_stb, 1);
        check("dq_no_b", fpu_b_stb, 0);
        check("dq_process", fpu_process, 3);
        check("dq_ad", fpu_ad, 64'h4010_0000_0000_0000);
        fpu_a_ack = 1'b1;
        tick();
        fpu_a_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("dq_wait_strobes", {fpu_a_stb, fpu_b_stb}, 0);
            tick();
        end
        fpu_zd = 64'h4000_0000_0000_0000; fpu_zs = 32'hDEAD_BEEF; fpu_z_stb = 1'b1;
        tick();
        check("dq_rsp_data", rsp_data, 64'h4000_0000_0000_0000);
        check("dq_rsp_op", rsp_op, 3);
        check("dq_rsp_tag", rsp_tag, 9);
        check("dq_rsp_lat", rsp_lat, 4);
        rsp_ready = 1'b1;
        tick();
        check("dq_drain_hold", cmd_ready, 0);
        fpu_z_stb = 1'b0;
        tick();
        rsp_ready = 1'b0;
        check("dq_idle", cmd_ready, 1);

        // Simultaneous A/B ack
        send(2'd2, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 4'd3);
        fpu_a_ack = 1'b1; fpu_b_ack = 1'b1;
        tick();
        fpu_a_ack = 1'b0; fpu_b_ack = 1'b0;
        check("sim_no_restrobe", {fpu_a_stb, fpu_b_stb}, 0);
        tick();
        check("sim_no_restrobe2", {fpu_a_stb, fpu_b_stb}, 0);
        fpu_zd = 64'h3FF0_0000_0000_0000; fpu_z_stb = 1'b1;
        #1;
        check("sim_in_wait_z", fpu_z_ack, 1);
        tick();
        fpu_z_stb = 1'b0;
        check("sim_rsp_data", rsp_data, 64'h3FF0_0000_0000_0000);
        check("sim_rsp_lat", rsp_lat, 3);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Backpressure: second result held off until the response register frees
        send(2'd0, 64'h1, 64'h2, 4'd1);
        fpu_a_ack = 1'b1; fpu_b_ack = 1'b1;
        tick();
        fpu_a_ack = 1'b0; fpu_b_ack = 1'b0;
        fpu_zs = 32'h1111_1111; fpu_z_stb = 1'b1;
        tick();
        fpu_z_stb = 1'b0;
        tick();
        check("bp_first_pending", rsp_valid, 1);
        send(2'd0, 64'h3, 64'h4, 4'd2);
        fpu_a_ack = 1'b1; fpu_b_ack = 1'b1;
        tick();
        fpu_a_ack = 1'b0; fpu_b_ack = 1'b0;
        fpu_zs = 32'h2222_2222; fpu_z_stb = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("bp_z_ack_held", fpu_z_ack, 0);
            check("bp_payload_stable", rsp_data, 64'h1111_1111);
            if (i == 2) rsp_ready = 1'b1;
            tick();
        end
        rsp_ready = 1'b0;
        #1;
        check("bp_freed", rsp_valid, 0);
        check("bp_z_ack_now", fpu_z_ack, 1);
        tick();
        check("bp_second_tag", rsp_tag, 2);
        check("bp_second_data", rsp_data, 64'h2222_2222);
        check("bp_second_lat", rsp_lat, 5);
        fpu_z_stb = 1'b0; rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Reset during WAIT_Z
        send(2'd2, 64'h5, 64'h6, 4'd7);
        fpu_a_ack = 1'b1; fpu_b_ack = 1'b1;
        tick();
        fpu_a_ack = 1'b0; fpu_b_ack = 1'b0;
        check("rz_in_wait", cmd_ready, 0);
        #2 rst = 1'b1;
        #1;
        check("rz_outputs_zero", {cmd_ready, fpu_a_stb, fpu_b_stb, fpu_z_ack, rsp_valid}, 0);
        check("rz_bus_zero", {fpu_process, fpu_ad[31:0]}, 0);
        tick();
        rst = 1'b0;
        fpu_zd = 64'hABCD; fpu_z_stb = 1'b1;
        #1;
        check("rz_ready_low_at_release", cmd_ready, 0);
        tick();
        check("rz_ready_after", cmd_ready, 1);
        check("rz_no_ack", fpu_z_ack, 0);
        tick();
        check("rz_no_response", rsp_valid, 0);
        fpu_z_stb = 1'b0;

`ifdef FPU_SEQ_TIMEOUT_EN
        // Watchdog with TIMEOUT_CYCLES = 16 and a result that never arrives
        send(2'd1, 64'h4080_0000, 64'h0, 4'hA);
        fpu_a_ack = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            fpu_a_ack = 1'b0;
            check("to_no_rsp_yet", rsp_valid, 0);
        end
        tick();
        check("to_rsp_valid", rsp_valid, 1);
        check("to_rsp_err", rsp_err, 1);
        check("to_rsp_data", rsp_data, 64'h7FF8_0000_0000_0000);
        check("to_rsp_lat", rsp_lat, 16);
        check("to_rsp_tag", rsp_tag, 4'hA);
        check("to_rsp_op", rsp_op, 1);
        check("to_strobes", {fpu_a_stb, fpu_b_stb, fpu_z_ack}, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("to_ready_held_low", cmd_ready, 0);
            tick();
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
